// File: rtl/dds_pkg.sv
// dds_pkg: shared state encoding, sweep mode codes and default widths for the DDS sweep logic
package dds_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DWELL, S_DONE} state_t;
  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;
  localparam int DDS_FREQ_W = 5;
  localparam int DDS_WAVE_W = 2;
endpackage

// File: rtl/dds_dwell_timer.sv
// dds_dwell_timer: loadable down-counter that flags when the current dwell has expired
module dds_dwell_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (en && !zero) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency-sweep sequencer feeding waveform and coarse frequency codes to dds_ctrl
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int FREQ_W  = DDS_FREQ_W,
  parameter int WAVE_W  = DDS_WAVE_W,
  parameter int DWELL_W = 24
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic               abort,
  input  logic [FREQ_W-1:0]  cfg_start_code,
  input  logic [FREQ_W-1:0]  cfg_stop_code,
  input  logic [FREQ_W-1:0]  cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  input  logic [WAVE_W-1:0]  cfg_wave,
  input  logic [WAVE_W-1:0]  manual_wave,
  input  logic [FREQ_W-1:0]  manual_freq,
  output logic [WAVE_W-1:0]  waveform_counter,
  output logic [FREQ_W-1:0]  freq_counter,
  output logic               busy,
  output logic               step_strobe,
  output logic               done,
  output logic               cfg_err
);
  state_t state_q, state_d;
  logic [WAVE_W-1:0] wave_q, wave_d, sh_wave_q, sh_wave_d;
  logic [FREQ_W-1:0] freq_q, freq_d, sh_start_q, sh_start_d, sh_stop_q, sh_stop_d, sh_step_q, sh_step_d;
  logic [DWELL_W-1:0] sh_dwell_q, sh_dwell_d;
  logic [1:0] sh_mode_q, sh_mode_d;
  logic up_q, up_d, leg_q, leg_d, busy_q, busy_d, strobe_q, strobe_d, done_q, done_d, err_q, err_d;
  logic [FREQ_W-1:0] tgt, alt;
  logic zero;

  // Clamped step toward t, computed one bit wider so neither direction can wrap
  function automatic logic [FREQ_W-1:0] step_to(input logic [FREQ_W-1:0] c, s, t, input logic up);
    logic [FREQ_W:0] sum, dif;
    sum = {1'b0, c} + {1'b0, s};
    dif = {1'b0, c} - {1'b0, s};
    if (up) return (sum > {1'b0, t}) ? t : sum[FREQ_W-1:0];
    return (dif[FREQ_W] || dif[FREQ_W-1:0] < t) ? t : dif[FREQ_W-1:0];
  endfunction

  dds_dwell_timer #(.W(DWELL_W)) u_timer (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .load     (state_q == S_LOAD || (state_q == S_DWELL && zero)),
    .en       (state_q == S_DWELL),
    .load_val (sh_dwell_q),
    .zero     (zero)
  );

  always_comb begin
    state_d    = state_q;
    wave_d     = wave_q;
    freq_d     = freq_q;
    up_d       = up_q;
    leg_d      = leg_q;
    strobe_d   = 1'b0;
    err_d      = 1'b0;
    sh_start_d = sh_start_q;
    sh_stop_d  = sh_stop_q;
    sh_step_d  = sh_step_q;
    sh_dwell_d = sh_dwell_q;
    sh_mode_d  = sh_mode_q;
    sh_wave_d  = sh_wave_q;
    tgt        = leg_q ? sh_start_q : sh_stop_q;
    alt        = leg_q ? sh_stop_q : sh_start_q;
    case (state_q)
      S_IDLE: begin
        wave_d = manual_wave;
        freq_d = manual_freq;
        if (start && !abort) begin
          if (cfg_step == '0) err_d = 1'b1;
          else begin
            sh_start_d = cfg_start_code;
            sh_stop_d  = cfg_stop_code;
            sh_step_d  = cfg_step;
            sh_dwell_d = cfg_dwell;
            sh_mode_d  = cfg_mode;
            sh_wave_d  = cfg_wave;
            state_d    = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        freq_d   = sh_start_q;
        wave_d   = sh_wave_q;
        up_d     = sh_stop_q >= sh_start_q;
        leg_d    = 1'b0;
        strobe_d = 1'b1;
        state_d  = S_DWELL;
      end
      S_DWELL: if (zero) begin
        strobe_d = 1'b1;
        if (freq_q != tgt) freq_d = step_to(freq_q, sh_step_q, tgt, up_q);
        else if (sh_mode_q == MODE_SAW) freq_d = sh_start_q;
        else if (sh_mode_q == MODE_TRI) begin
          up_d   = !up_q;
          leg_d  = !leg_q;
          freq_d = step_to(freq_q, sh_step_q, alt, !up_q);
        end else begin
          strobe_d = 1'b0;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort freezes the outputs for one edge; pass-through resumes from IDLE
    if (abort && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      strobe_d = 1'b0;
      freq_d   = freq_q;
      wave_d   = wave_q;
      up_d     = up_q;
      leg_d    = leg_q;
    end
    busy_d = state_d != S_IDLE;
    done_d = state_d == S_DONE;
  end

  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state_q    <= S_IDLE;
      wave_q     <= '0;
      freq_q     <= '0;
      up_q       <= 1'b1;
      leg_q      <= 1'b0;
      busy_q     <= 1'b0;
      strobe_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      sh_start_q <= '0;
      sh_stop_q  <= '0;
      sh_step_q  <= '0;
      sh_dwell_q <= '0;
      sh_mode_q  <= '0;
      sh_wave_q  <= '0;
    end else begin
      state_q    <= state_d;
      wave_q     <= wave_d;
      freq_q     <= freq_d;
      up_q       <= up_d;
      leg_q      <= leg_d;
      busy_q     <= busy_d;
      strobe_q   <= strobe_d;
      done_q     <= done_d;
      err_q      <= err_d;
      sh_start_q <= sh_start_d;
      sh_stop_q  <= sh_stop_d;
      sh_step_q  <= sh_step_d;
      sh_dwell_q <= sh_dwell_d;
      sh_mode_q  <= sh_mode_d;
      sh_wave_q  <= sh_wave_d;
    end

  assign waveform_counter = wave_q;
  assign freq_counter     = freq_q;
  assign busy             = busy_q;
  assign step_strobe      = strobe_q;
  assign done             = done_q;
  assign cfg_err          = err_q;
endmodule
